// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path.
//   OVERSAMPLE   : s_tick pulses per serial bit period
//   uart_state_t : receiver FSM state encoding
//   tick_width() : width of a tick counter that must reach a given count
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // A tick counter always has to reach OVERSAMPLE-1 for the data bits and
    // may have to reach a longer count for the stop period (two stop bits).
    function automatic int tick_width(input int max_ticks);
        int w;
        w = $clog2(max_ticks);
        if (w < $clog2(OVERSAMPLE)) begin
            w = $clog2(OVERSAMPLE);
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
// Receiver-to-FIFO bus: received byte, its write strobe, the FIFO full flag
// and the per-frame error pulses.
//   dout         : received byte, LSB aligned
//   rx_done_tick : one-clk write strobe for the downstream FIFO
//   fifo_full    : full flag returned by the downstream FIFO
//   frame_err    : one-clk pulse, stop bit sampled low
//   parity_err   : one-clk pulse, parity mismatch
//   overrun_err  : one-clk pulse, byte delivered while FIFO full
// Modports: master = receiver side, slave = FIFO / consumer side.
// -----------------------------------------------------------------------------
interface uart_rx_if;

    logic [7:0] dout;
    logic       rx_done_tick;
    logic       fifo_full;
    logic       frame_err;
    logic       parity_err;
    logic       overrun_err;

    modport master (
        output dout,
        output rx_done_tick,
        output frame_err,
        output parity_err,
        output overrun_err,
        input  fifo_full
    );

    modport slave (
        input  dout,
        input  rx_done_tick,
        input  frame_err,
        input  parity_err,
        input  overrun_err,
        output fifo_full
    );

endinterface

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous level.
//   clk   : destination clock
//   reset : asynchronous, active-high; both flops load RESET_VAL
//   d     : asynchronous input
//   q     : synchronized output
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // First flop may go metastable; the second gives it a full clock to
    // resolve. Reset loads the idle level so a serial line reads as idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 16x oversampling UART receiver feeding a FIFO.
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high
//   s_tick : one-clk pulse at 16x the baud rate
//   rx     : asynchronous serial line, idle high
//   bus    : uart_rx_if.master (dout, rx_done_tick, error pulses, fifo_full)
// Parameters:
//   DBIT       : data bits per frame (5..8)
//   SB_TICK    : s_ticks in the stop period (16 = 1 stop bit, 32 = 2)
//   PARITY_ODD : 1 = odd, 0 = even parity (only with UART_RX_PARITY_EN)
// Build option:
//   UART_RX_PARITY_EN : adds a parity bit after the data bits and checks it;
//                       when undefined parity_err is constant 0.
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      s_tick,
    input  logic      rx,
    uart_rx_if.master bus
);

    localparam int SW = tick_width(SB_TICK);
    localparam logic [SW-1:0] MID_TICK  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] BIT_TICK  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] STOP_TICK = SW'(SB_TICK - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DBIT - 1);

    logic rx_s;

    uart_state_t     state_reg, state_next;
    logic [SW-1:0]   s_reg, s_next;
    logic [2:0]      n_reg, n_next;
    logic [DBIT-1:0] b_reg, b_next;
    logic [7:0]      dout_reg, dout_next;
    logic            done_reg, done_next;
    logic            ferr_reg, ferr_next;
    logic            perr_reg, perr_next;
    logic            oerr_reg, oerr_next;
    logic            parity_ok;

`ifdef UART_RX_PARITY_EN
    logic p_reg, p_next;
`else
    wire unused_parity_cfg = PARITY_ODD;
`endif

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (rx),
        .q    (rx_s)
    );

`ifdef UART_RX_PARITY_EN
    // Data bits plus the received parity bit must XOR to the selected
    // parity: 0 for even, 1 for odd.
    assign parity_ok = ((^b_reg) ^ p_reg) == PARITY_ODD;
`else
    assign parity_ok = 1'b1;
`endif

    // State register and registered outputs. All pulse outputs are computed
    // one step early by the next-state logic so they leave here glitch-free,
    // and dout changes on the same edge that raises rx_done_tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            s_reg     <= '0;
            n_reg     <= '0;
            b_reg     <= '0;
            dout_reg  <= '0;
            done_reg  <= 1'b0;
            ferr_reg  <= 1'b0;
            perr_reg  <= 1'b0;
            oerr_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            p_reg     <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            b_reg     <= b_next;
            dout_reg  <= dout_next;
            done_reg  <= done_next;
            ferr_reg  <= ferr_next;
            perr_reg  <= perr_next;
            oerr_reg  <= oerr_next;
`ifdef UART_RX_PARITY_EN
            p_reg     <= p_next;
`endif
        end
    end

    // Next-state logic. IDLE reacts to the synchronized line on any clock so
    // a start edge right after a stop bit is never missed; every other state
    // only moves on s_tick. START waits half a bit to land in the middle of
    // the start bit and re-checks it, rejecting short glitches; from there
    // each later sample is a full bit period apart, i.e. mid-bit.
    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        b_next     = b_reg;
        dout_next  = dout_reg;
        done_next  = 1'b0;
        ferr_next  = 1'b0;
        perr_next  = 1'b0;
        oerr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
        p_next     = p_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    s_next     = '0;
                end
            end

            START: begin
                if (s_tick) begin
                    if (s_reg == MID_TICK) begin
                        if (!rx_s) begin
                            state_next = DATA;
                            s_next     = '0;
                            n_next     = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end

            DATA: begin
                if (s_tick) begin
                    if (s_reg == BIT_TICK) begin
                        s_next = '0;
                        b_next = {rx_s, b_reg[DBIT-1:1]};
                        if (n_reg == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            n_next = n_reg + 1'b1;
                        end
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_reg == BIT_TICK) begin
                        p_next     = rx_s;
                        s_next     = '0;
                        state_next = STOP;
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
`endif

            // A low stop bit takes priority over a parity mismatch. The byte
            // is always handed over on a good frame even if the FIFO is full;
            // the FIFO drops it and overrun_err flags the loss.
            STOP: begin
                if (s_tick) begin
                    if (s_reg == STOP_TICK) begin
                        state_next = IDLE;
                        if (!rx_s) begin
                            ferr_next = 1'b1;
                        end else if (!parity_ok) begin
                            perr_next = 1'b1;
                        end else begin
                            done_next = 1'b1;
                            dout_next = 8'(b_reg);
                            oerr_next = bus.fifo_full;
                        end
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.dout         = dout_reg;
    assign bus.rx_done_tick = done_reg;
    assign bus.frame_err    = ferr_reg;
    assign bus.overrun_err  = oerr_reg;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err   = perr_reg;
`else
    assign bus.parity_err   = 1'b0;
`endif

endmodule
